// File: rtl/fifo_pkg.sv
// Shared sizing constants for the single-clock FIFO.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 4;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port, registered read port.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array write; contents are left untouched by clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds unless a read is accepted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Registered read data with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/a_fifo.sv
// Single-clock FIFO: pointer bookkeeping, request qualification and flags.
module a_fifo #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Empty_out,
    input  logic                  ReadEn_in,
    input  logic                  Clk,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  Full_out,
    input  logic                  WriteEn_in,
    input  logic                  Clear_in
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wptr_d, wptr_q;
    logic [ADDR_WIDTH:0] rptr_d, rptr_q;
    logic                wr_ok;
    logic                rd_ok;
    logic                empty;
    logic                full;

    // Flags depend only on registered pointers; the MSB is the wrap bit.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    end

    // Accept requests only away from the blocking boundary and outside clear.
    always_comb begin
        wr_ok  = WriteEn_in && !full && !Clear_in;
        rd_ok  = ReadEn_in && !empty && !Clear_in;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Pointer registers with synchronous clear.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (Clk),
        .clear   (Clear_in),
        .wr_en   (wr_ok),
        .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
        .wr_data (Data_in),
        .rd_en   (rd_ok),
        .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
        .rd_data (Data_out)
    );

    assign Empty_out = empty;
    assign Full_out  = full;

endmodule

// File: tb/tb_a_fifo.sv
// Directed bench for a_fifo: vector table for fill/drain, queue model for the rest.
module tb_a_fifo;

    logic       Clk;
    logic       Clear_in;
    logic       WriteEn_in;
    logic       ReadEn_in;
    logic [3:0] Data_in;
    logic [3:0] Data_out;
    logic       Empty_out;
    logic       Full_out;

    int checks;
    int errors;

    logic [3:0] mq[$];
    logic [3:0] mdout;

    typedef struct {
        logic       clr;
        logic       we;
        logic       re;
        logic [3:0] din;
        logic       e;
        logic       f;
        logic [3:0] d;
    } vec_t;

    vec_t tbl[19];

    a_fifo dut (
        .Data_out   (Data_out),
        .Empty_out  (Empty_out),
        .ReadEn_in  (ReadEn_in),
        .Clk        (Clk),
        .Data_in    (Data_in),
        .Full_out   (Full_out),
        .WriteEn_in (WriteEn_in),
        .Clear_in   (Clear_in)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(logic clr, logic we, logic re, logic [3:0] din,
                                logic e, logic f, logic [3:0] d);
        vec_t v;
        v.clr = clr; v.we = we; v.re = re; v.din = din;
        v.e = e; v.f = f; v.d = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic drive(input logic clr, input logic we, input logic re, input logic [3:0] din);
        @(negedge Clk);
        Clear_in   = clr;
        WriteEn_in = we;
        ReadEn_in  = re;
        Data_in    = din;
        @(posedge Clk);
        #1;
    endtask

    // Queue-based reference: one cycle of behaviour, then compare all outputs.
    task automatic mstep(input string name, input logic clr, input logic we,
                         input logic re, input logic [3:0] din);
        logic r_ok, w_ok;
        drive(clr, we, re, din);
        if (clr) begin
            mq.delete();
            mdout = 4'd0;
        end else begin
            r_ok = re && (mq.size() > 0);
            w_ok = we && (mq.size() < 8);
            if (r_ok) mdout = mq.pop_front();
            if (w_ok) mq.push_back(din);
        end
        chk({name, ".dout"},  Data_out,         mdout);
        chk({name, ".empty"}, {3'b0, Empty_out}, {3'b0, mq.size() == 0});
        chk({name, ".full"},  {3'b0, Full_out},  {3'b0, mq.size() == 8});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clear_in = 1'b1; WriteEn_in = 1'b0; ReadEn_in = 1'b0; Data_in = 4'd0;

        // Fill 3..10, rejected 9th write of 11, then 10 reads.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1'b0, 1'b1, 1'b0, 4'(i + 3), 1'b0, (i == 7), 4'd0);
        tbl[8] = mk(1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 8; i++)
            tbl[9 + i] = mk(1'b0, 1'b0, 1'b1, 4'd0, (i == 7), 1'b0, 4'(i + 3));
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd10);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd10);

        // Reset held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd0);
        end
        chk("reset.dout",  Data_out,           4'd0);
        chk("reset.empty", {3'b0, Empty_out},  4'd1);
        chk("reset.full",  {3'b0, Full_out},   4'd0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].clr, tbl[i].we, tbl[i].re, tbl[i].din);
            chk($sformatf("vec%0d.dout", i),  Data_out,          tbl[i].d);
            chk($sformatf("vec%0d.empty", i), {3'b0, Empty_out}, {3'b0, tbl[i].e});
            chk($sformatf("vec%0d.full", i),  {3'b0, Full_out},  {3'b0, tbl[i].f});
        end

        // Simultaneous read/write with 4 words stored.
        mstep("sim.clr", 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) mstep("sim.fill", 1'b0, 1'b1, 1'b0, 4'(i + 1));
        for (int i = 0; i < 6; i++) mstep("sim.both", 1'b0, 1'b1, 1'b1, 4'(i + 5));
        chk("sim.out6", Data_out, 4'd6);

        // Both enables at full: the read happens, the write is dropped.
        for (int i = 0; i < 4; i++) mstep("full.fill", 1'b0, 1'b1, 1'b0, 4'(i + 11));
        mstep("full.both", 1'b0, 1'b1, 1'b1, 4'd15);
        chk("full.both.full", {3'b0, Full_out}, 4'd0);
        for (int i = 0; i < 7; i++) mstep("full.drain", 1'b0, 1'b0, 1'b1, 4'd0);
        chk("full.drain.last", Data_out, 4'd14);

        // Both enables at empty: only the write happens.
        mstep("empty.both", 1'b0, 1'b1, 1'b1, 4'd9);
        chk("empty.both.dout", Data_out, 4'd14);
        mstep("empty.rd", 1'b0, 1'b0, 1'b1, 4'd0);
        chk("empty.rd.dout", Data_out, 4'd9);

        // 20 write/read pairs across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            mstep("wrap.wr", 1'b0, 1'b1, 1'b0, 4'(i % 16));
            mstep("wrap.rd", 1'b0, 1'b0, 1'b1, 4'd0);
        end
        chk("wrap.last", Data_out, 4'd3);

        // Clear mid-operation with a concurrent write.
        for (int i = 0; i < 5; i++) mstep("mid.fill", 1'b0, 1'b1, 1'b0, 4'(i + 2));
        mstep("mid.clr", 1'b1, 1'b1, 1'b0, 4'd12);
        chk("mid.clr.empty", {3'b0, Empty_out}, 4'd1);
        mstep("mid.wr", 1'b0, 1'b1, 1'b0, 4'd7);
        mstep("mid.rd", 1'b0, 1'b0, 1'b1, 4'd0);
        chk("mid.rd.dout", Data_out, 4'd7);
        chk("mid.rd.empty", {3'b0, Empty_out}, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
